// File: rtl/ddr3_iod_dly_ctrl_if.sv
// ----------------------------------------------------------------------------
// ddr3_iod_dly_ctrl_if
// Bundles the tap-adjust command handshake and the IOD dynamic delay-line
// signals of one ddr3_iod_dly_ctrl instance.
//
// Signals:
//   CMD_VALID / CMD_READY      command handshake
//   CMD_OP[1:0]                00 inc, 01 dec, 10 load INIT_TAP, 11 no-op
//   CMD_STEPS[TAP_W-1:0]       tap count for inc/dec
//   DONE, STATUS_OOR           completion pulse and range-limit status
//   TAP_POS[TAP_W-1:0]         shadow tap position
//   DELAY_LINE_MOVE / _DIRECTION / _LOAD   to the IOD
//   DELAY_LINE_OUT_OF_RANGE    from the IOD
//
// Modports:
//   master : calibration logic plus IOD side (drives commands and OOR)
//   slave  : the delay controller itself
// ----------------------------------------------------------------------------
interface ddr3_iod_dly_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [TAP_W-1:0] CMD_STEPS;
    logic             DONE;
    logic             STATUS_OOR;
    logic [TAP_W-1:0] TAP_POS;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_LOAD;
    logic             DELAY_LINE_OUT_OF_RANGE;

    modport master (
        output CMD_VALID, CMD_OP, CMD_STEPS, DELAY_LINE_OUT_OF_RANGE,
        input  CMD_READY, DONE, STATUS_OOR, TAP_POS,
               DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_STEPS, DELAY_LINE_OUT_OF_RANGE,
        output CMD_READY, DONE, STATUS_OOR, TAP_POS,
               DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
    );
endinterface

// File: rtl/ddr3_iod_dly_ctrl.sv
// ----------------------------------------------------------------------------
// ddr3_iod_dly_ctrl
// Fabric-side initiator for the dynamic delay-line port of one DDR3 PHY IOD.
// Turns single tap-adjust commands into paced DELAY_LINE_MOVE/DIRECTION/LOAD
// pulses, watches DELAY_LINE_OUT_OF_RANGE and keeps a shadow tap position.
//
// Parameters:
//   TAP_W      tap position width (MAX_TAP = 2^TAP_W-1)
//   GAP_CYCLES idle cycles after every MOVE/LOAD pulse (>= 1)
//   INIT_TAP   tap value after reset or LOAD
//
// Ports:
//   FAB_CLK     in   fabric clock, rising edge
//   SYNC_RST_N  in   synchronous active-low reset
//   dl          slave modport of ddr3_iod_dly_ctrl_if (command + IOD signals)
//
// All outputs come straight from flops; they are loaded from the next-state
// decode so each pulse lines up with the state it belongs to.
// ----------------------------------------------------------------------------
module ddr3_iod_dly_ctrl #(
    parameter int TAP_W      = 8,
    parameter int GAP_CYCLES = 3,
    parameter int INIT_TAP   = 1
) (
    input  logic               FAB_CLK,
    input  logic               SYNC_RST_N,
    ddr3_iod_dly_ctrl_if.slave dl
);

    localparam logic [TAP_W-1:0] MAX_TAP  = '1;
    localparam logic [TAP_W-1:0] INIT_VAL = TAP_W'(INIT_TAP);
    localparam int               CW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0]    GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOVE,
        S_GAP,
        S_LOAD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_done;
    logic             r_oor;
    logic [TAP_W-1:0] r_tap;
    logic             r_move;
    logic             r_dir;
    logic             r_load;
    logic [TAP_W-1:0] r_steps;
    logic [CW-1:0]    r_gap_cnt;
    logic             r_is_load;

    state_t           w_next;
    logic             w_accept;
    logic             w_oor;
    logic [TAP_W-1:0] w_tap;
    logic [TAP_W-1:0] w_tap_step;
    logic             w_dir;
    logic [TAP_W-1:0] w_steps;
    logic [CW-1:0]    w_gap;
    logic             w_is_load;

    // True when one more step in direction dir would leave the tap range.
    function automatic logic f_at_limit(input logic dir, input logic [TAP_W-1:0] tap);
        return dir ? (tap == MAX_TAP) : (tap == '0);
    endfunction

    // r_ready is only ever high in IDLE, so it doubles as the accept qualifier.
    assign w_accept = dl.CMD_VALID & r_ready;

    always_comb begin
        w_next     = r_state;
        w_oor      = r_oor;
        w_tap      = r_tap;
        w_dir      = r_dir;
        w_steps    = r_steps;
        w_gap      = r_gap_cnt;
        w_is_load  = r_is_load;
        w_tap_step = r_dir ? (r_tap + TAP_W'(1)) : (r_tap - TAP_W'(1));

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_oor = 1'b0;
                    case (dl.CMD_OP)
                        2'b00, 2'b01: begin
                            if (dl.CMD_STEPS != '0) begin
                                w_dir     = ~dl.CMD_OP[0];
                                w_steps   = dl.CMD_STEPS;
                                w_is_load = 1'b0;
                                w_next    = S_SETUP;
                            end else begin
                                w_next = S_DONE;
                            end
                        end
                        2'b10: begin
                            w_is_load = 1'b1;
                            w_next    = S_LOAD;
                        end
                        default: w_next = S_DONE;
                    endcase
                end
            end

            S_SETUP: begin
                if (f_at_limit(r_dir, r_tap)) begin
                    w_oor  = 1'b1;
                    w_next = S_DONE;
                end else begin
                    w_next = S_MOVE;
                end
            end

            S_MOVE, S_LOAD: begin
                w_gap  = '0;
                w_next = S_GAP;
            end

            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (r_is_load) begin
                        w_tap  = INIT_VAL;
                        w_next = S_DONE;
                    end else if (dl.DELAY_LINE_OUT_OF_RANGE) begin
                        w_oor  = 1'b1;
                        w_next = S_DONE;
                    end else begin
                        w_tap   = w_tap_step;
                        w_steps = r_steps - TAP_W'(1);
                        if (r_steps == TAP_W'(1)) begin
                            w_next = S_DONE;
                        end else if (f_at_limit(r_dir, w_tap_step)) begin
                            // Pre-check for the next MOVE uses the tap just updated.
                            w_oor  = 1'b1;
                            w_next = S_DONE;
                        end else begin
                            w_next = S_MOVE;
                        end
                    end
                end else begin
                    w_gap = r_gap_cnt + CW'(1);
                end
            end

            S_DONE:  w_next = S_IDLE;

            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!SYNC_RST_N) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_oor     <= 1'b0;
            r_tap     <= INIT_VAL;
            r_move    <= 1'b0;
            r_dir     <= 1'b0;
            r_load    <= 1'b0;
            r_steps   <= '0;
            r_gap_cnt <= '0;
            r_is_load <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ready   <= (w_next == S_IDLE);
            r_done    <= (w_next == S_DONE);
            r_move    <= (w_next == S_MOVE);
            r_load    <= (w_next == S_LOAD);
            r_oor     <= w_oor;
            r_tap     <= w_tap;
            r_dir     <= w_dir;
            r_steps   <= w_steps;
            r_gap_cnt <= w_gap;
            r_is_load <= w_is_load;
        end
    end

    assign dl.CMD_READY            = r_ready;
    assign dl.DONE                 = r_done;
    assign dl.STATUS_OOR           = r_oor;
    assign dl.TAP_POS              = r_tap;
    assign dl.DELAY_LINE_MOVE      = r_move;
    assign dl.DELAY_LINE_DIRECTION = r_dir;
    assign dl.DELAY_LINE_LOAD      = r_load;

endmodule

// File: doc/ddr3_iod_dly_ctrl.md
# ddr3_iod_dly_ctrl

Fabric-side initiator for the dynamic delay-line port of a DDR3 PHY IOD lane (address/command or data). It converts single tap-adjust commands from the training/calibration logic into correctly paced DELAY_LINE_MOVE, DELAY_LINE_DIRECTION and DELAY_LINE_LOAD pulses. It monitors DELAY_LINE_OUT_OF_RANGE and keeps a shadow copy of the current tap position. One instance sits beside each IOD whose DYN_DELAY_LINE_EN is set, clocked by the same FAB_CLK as the IOD TX_CLK.

## Interface
Parameters:
- TAP_W, 8: tap position width; MAX_TAP = 2^TAP_W-1.
- GAP_CYCLES, 3: idle cycles after every MOVE/LOAD pulse before the next action (min 1).
- INIT_TAP, 1: tap value after reset or LOAD; equals the IOD's static TX_DELAY_VAL/RX_DELAY_VAL.

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- SYNC_RST_N  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  2  00 increment, 01 decrement, 10 load to INIT_TAP, 11 reserved (no-op).
- CMD_STEPS  in  TAP_W  tap count for inc/dec; ignored for load.
- DONE  out  1  one-cycle completion pulse.
- STATUS_OOR  out  1  command ended on a range limit; valid while DONE=1, held until next accept.
- TAP_POS  out  TAP_W  shadow tap position.
- DELAY_LINE_MOVE  out  1  to IOD DELAY_LINE_MOVE.
- DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment.
- DELAY_LINE_LOAD  out  1  to IOD DELAY_LINE_LOAD.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD.

## Operation
- States: IDLE, SETUP, MOVE, GAP, LOAD, DONE.
- IDLE: CMD_READY=1. Accept on CMD_VALID&CMD_READY. CMD_OP and CMD_STEPS are captured at accept; later input changes are ignored.
- Inc/dec with steps>0: DIRECTION is registered at accept, then go to SETUP. DIRECTION holds its value until the next inc/dec accept.
- SETUP: one cycle so that DIRECTION is stable before the first MOVE.
- Boundary pre-check on entering MOVE:
  - Inc with TAP_POS==MAX_TAP, or dec with TAP_POS==0: no pulse; go to DONE with STATUS_OOR=1.
  - Otherwise MOVE=1 for exactly one cycle, then GAP.
- GAP: GAP_CYCLES cycles with MOVE=0. DELAY_LINE_OUT_OF_RANGE is sampled on the last gap cycle.
  - OOR=0: TAP_POS updates ±1 on that cycle; remaining step count decrements; go to MOVE if steps remain, else DONE.
  - OOR=1: TAP_POS is not updated; remaining steps are abandoned; go to DONE with STATUS_OOR=1.
- Load: LOAD=1 for one cycle, then GAP_CYCLES cycles. TAP_POS=INIT_TAP on the last gap cycle. Then DONE with STATUS_OOR=0. OOR is ignored during load.
- Steps==0 or op 11: accept then go directly to DONE; no pulses; STATUS_OOR=0.
- DONE: DONE=1, CMD_READY=0 for one cycle, then IDLE.
- MOVE and LOAD are never asserted in the same cycle. At most one MOVE per 1+GAP_CYCLES cycles.
- TAP_POS arithmetic is unsigned TAP_W-bit. The pre-check guarantees no wrap-around.

## Timing
- Reset (SYNC_RST_N=0 at an edge):
  - State becomes IDLE.
  - CMD_READY=0 while reset is held; 1 in the first cycle after release.
  - DONE, STATUS_OOR, MOVE, DIRECTION and LOAD are 0; TAP_POS=INIT_TAP.
  - Reset mid-command aborts immediately: a pulse in flight is dropped and no DONE is issued.
- Accept at cycle 0 with inc/dec of N steps, no limits hit:
  - SETUP in cycle 1.
  - MOVE in cycles 2+k·(1+GAP_CYCLES), k=0..N-1.
  - DONE in cycle 2+N·(1+GAP_CYCLES); CMD_READY=1 in the following cycle.
- Load accepted at cycle 0: LOAD in cycle 1; DONE in cycle 2+GAP_CYCLES.
- No-op accepted at cycle 0: DONE in cycle 1.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset release, then inc 3 steps (GAP_CYCLES=3): MOVE in cycles 2, 6, 10 with DIRECTION=1 from cycle 1; DONE in cycle 14; TAP_POS=4; STATUS_OOR=0.
- Dec 2 from TAP_POS=4: MOVE in cycles 2 and 6 with DIRECTION=0; DONE in cycle 10; TAP_POS=2.
- Dec 5 from TAP_POS=2: two MOVE pulses; TAP_POS=0; DONE in cycle 10 with STATUS_OOR=1; no third MOVE.
- Inc 4 with OUT_OF_RANGE forced high after the second MOVE: exactly two MOVE pulses; TAP_POS=start+1; DONE with STATUS_OOR=1 in cycle 10.
- Load after several incs: LOAD in cycle 1 only; DONE in cycle 5; TAP_POS=1; STATUS_OOR=0. Also: steps=0 gives DONE in cycle 1 with no pulses.
- SYNC_RST_N low for one cycle in the gap after the first MOVE: no further MOVE; no DONE; TAP_POS=1; CMD_READY=1 in the cycle after release.
